// File: rtl/ifm_s2mm_axis.sv
// ifm_s2mm_axis: drains the good-frame FIFO onto an AXI4-Stream data master plus a per-frame status master
module ifm_s2mm_axis #(
    parameter int C_LEN_W = 16,
    parameter int C_SEQ_W = 16
) (
    input  logic        s2mm_clk,
    input  logic        rx_reset,
    input  logic [72:0] good_fifo_rdata,
    input  logic        good_fifo_empty,
    output logic        good_fifo_rden,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] sts_axis_tdata,
    output logic        sts_axis_tvalid,
    input  logic        sts_axis_tready
);
    logic               a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [72:0]        a_q, a_d, b_q, b_d;
    logic [C_LEN_W-1:0] cnt_q, cnt_d, len;
    logic [C_SEQ_W-1:0] seq_q, seq_d;
    logic               pend_q, pend_d, sts_vld_q, sts_vld_d;
    logic [31:0]        sts_q, sts_d;
    logic               xfer, xfer_last, last_block;
    logic [1:0]         occ;
    logic [C_LEN_W:0]   sum;

    assign xfer       = a_vld_q & m_axis_tready;
    assign xfer_last  = xfer & a_q[72];
    assign occ        = 2'(a_vld_q) + 2'(b_vld_q) - 2'(xfer);
    // a last word waits in the FIFO while another last is buffered or status is still pending
    assign last_block = good_fifo_rdata[72] & (pend_q | sts_vld_q);
    assign good_fifo_rden = !rx_reset & !good_fifo_empty & (occ < 2'd2) & !last_block;
    assign sum = {1'b0, cnt_q} + (C_LEN_W+1)'($countones(a_q[71:64]));
    assign len = sum[C_LEN_W] ? '1 : sum[C_LEN_W-1:0];

    assign m_axis_tdata    = a_q[63:0];
    assign m_axis_tkeep    = a_q[71:64];
    assign m_axis_tlast    = a_q[72];
    assign m_axis_tvalid   = a_vld_q;
    assign sts_axis_tdata  = sts_q;
    assign sts_axis_tvalid = sts_vld_q;

    // skid-buffer shift/fill, byte counting and status generation
    always_comb begin
        a_vld_d   = xfer ? b_vld_q : a_vld_q;
        a_d       = xfer ? b_q : a_q;
        b_vld_d   = b_vld_q & !xfer;
        b_d       = b_q;
        if (good_fifo_rden) begin
            if (!a_vld_d) begin
                a_vld_d = 1'b1;
                a_d     = good_fifo_rdata;
            end else begin
                b_vld_d = 1'b1;
                b_d     = good_fifo_rdata;
            end
        end
        pend_d    = (good_fifo_rden & good_fifo_rdata[72]) | (pend_q & !xfer_last);
        cnt_d     = xfer ? (a_q[72] ? '0 : len) : cnt_q;
        seq_d     = xfer_last ? seq_q + C_SEQ_W'(1) : seq_q;
        sts_vld_d = xfer_last | (sts_vld_q & !sts_axis_tready);
        sts_d     = xfer_last ? (32'(len) | (32'(seq_q) << 16)) : sts_q;
    end

    // state registers with asynchronous reset
    always_ff @(posedge s2mm_clk or posedge rx_reset) begin
        if (rx_reset) begin
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            seq_q     <= '0;
            pend_q    <= 1'b0;
            sts_vld_q <= 1'b0;
            sts_q     <= '0;
        end else begin
            a_vld_q   <= a_vld_d;
            b_vld_q   <= b_vld_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            seq_q     <= seq_d;
            pend_q    <= pend_d;
            sts_vld_q <= sts_vld_d;
            sts_q     <= sts_d;
        end
    end
endmodule

// File: tb/tb_ifm_s2mm_axis.sv
// tb_ifm_s2mm_axis: scoreboard bench for ifm_s2mm_axis with a FIFO model and a frame-length/sequence model
module tb_ifm_s2mm_axis;
    localparam int DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rx_reset = 1'b1;
    logic [72:0] good_fifo_rdata;
    logic        good_fifo_empty;
    logic        good_fifo_rden;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [31:0] sts_axis_tdata;
    logic        sts_axis_tvalid;
    logic        sts_axis_tready = 1'b1;

    logic [72:0] mem [DEPTH];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    bit          flush = 1'b0;
    logic [72:0] exp_q [$];
    logic [31:0] sts_q [$];
    int          mcnt = 0;
    int          mseq = 0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_cyc = 0;
    bit          stalled = 1'b0;
    bit          sts_stall = 1'b0;
    bit          sts_prev = 1'b0;
    logic [72:0] held;
    logic [31:0] sts_held;

    ifm_s2mm_axis dut (
        .s2mm_clk        (clk),
        .rx_reset        (rx_reset),
        .good_fifo_rdata (good_fifo_rdata),
        .good_fifo_empty (good_fifo_empty),
        .good_fifo_rden  (good_fifo_rden),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .sts_axis_tdata  (sts_axis_tdata),
        .sts_axis_tvalid (sts_axis_tvalid),
        .sts_axis_tready (sts_axis_tready)
    );

    always #5 clk = ~clk;

    assign good_fifo_rdata = mem[rd_ptr % DEPTH];
    assign good_fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (flush) rd_ptr <= wr_ptr;
        else if (good_fifo_rden) rd_ptr <= rd_ptr + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [7:0] k, input logic l);
        mem[wr_ptr % DEPTH] = {l, k, d};
        wr_ptr++;
        exp_q.push_back({l, k, d});
        mcnt += $countones(k);
        if (mcnt > 65535) mcnt = 65535;
        if (l) begin
            sts_q.push_back({mseq[15:0], mcnt[15:0]});
            mseq = (mseq + 1) % 65536;
            mcnt = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input int bound, input bit rnd);
        int n = 0;
        while ((exp_q.size() != 0 || sts_q.size() != 0) && n < bound) begin
            @(posedge clk);
            #1;
            if (rnd) begin
                m_axis_tready   = 1'($urandom_range(0, 1));
                sts_axis_tready = 1'($urandom_range(0, 1));
            end
            n++;
        end
        if (n >= bound) chk("drain_timeout", 1, 0);
        m_axis_tready   = 1'b1;
        sts_axis_tready = 1'b1;
        tick(2);
    endtask

    // data/status monitor: scoreboard compare, hold-while-stalled and status latency
    always @(negedge clk) begin
        if (rx_reset) begin
            stalled   = 1'b0;
            sts_stall = 1'b0;
            sts_prev  = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 128'(m_axis_tvalid), 1);
                chk("hold_data", 128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 128'(held));
            end
            if (sts_stall) begin
                chk("sts_hold_valid", 128'(sts_axis_tvalid), 1);
                chk("sts_hold_data", 128'(sts_axis_tdata), 128'(sts_held));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) chk("extra_beat", 1, 0);
                else chk("beat", 128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 128'(exp_q.pop_front()));
                if (m_axis_tlast) last_cyc = cyc;
            end
            if (sts_axis_tvalid && !sts_prev) chk("sts_latency", 128'(cyc), 128'(last_cyc + 1));
            if (sts_axis_tvalid && sts_axis_tready) begin
                if (sts_q.size() == 0) chk("extra_sts", 1, 0);
                else chk("sts", 128'(sts_axis_tdata), 128'(sts_q.pop_front()));
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            held      = {m_axis_tlast, m_axis_tkeep, m_axis_tdata};
            sts_stall = sts_axis_tvalid && !sts_axis_tready;
            sts_held  = sts_axis_tdata;
            sts_prev  = sts_axis_tvalid;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_tvalid", 128'(m_axis_tvalid), 0);
        chk("rst_tdata", 128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 0);
        chk("rst_sts_tvalid", 128'(sts_axis_tvalid), 0);
        chk("rst_sts_tdata", 128'(sts_axis_tdata), 0);
        chk("rst_rden", 128'(good_fifo_rden), 0);
        rx_reset = 1'b0;
        tick(2);

        // three-word frame, 20 bytes
        push(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
        push(64'h5555_6666_7777_8888, 8'hFF, 1'b0);
        push(64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1);
        drain(50, 1'b0);

        // two single-word frames with status held off
        sts_axis_tready = 1'b0;
        push(64'h0000_0000_0000_00A5, 8'h01, 1'b1);
        push(64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b1);
        tick(10);
        chk("t2_sts_valid", 128'(sts_axis_tvalid), 1);
        chk("t2_sts_data", 128'(sts_axis_tdata), 128'(sts_q[0]));
        chk("t2_rden_blocked", 128'(good_fifo_rden), 0);
        chk("t2_tvalid_low", 128'(m_axis_tvalid), 0);
        chk("t2_head_waiting", 128'(good_fifo_empty), 0);
        sts_axis_tready = 1'b1;
        drain(50, 1'b0);

        // last beat with empty keep still yields status
        push(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
        push(64'h0, 8'h00, 1'b1);
        drain(50, 1'b0);

        // 64-word frame under random backpressure
        for (int i = 0; i < 64; i++) push({$urandom, $urandom}, 8'hFF, i == 63);
        drain(2000, 1'b1);

        // FIFO runs dry mid-frame
        for (int i = 0; i < 3; i++) push({$urandom, $urandom}, 8'h3F, 1'b0);
        drain(50, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("gap_tvalid", 128'(m_axis_tvalid), 0);
            tick(1);
        end
        push({$urandom, $urandom}, 8'hFF, 1'b0);
        push({$urandom, $urandom}, 8'h07, 1'b1);
        drain(50, 1'b0);

        // 70000-byte frame saturates, then a short frame restarts the count
        for (int i = 0; i < 8750; i++) push({$urandom, $urandom}, 8'hFF, i == 8749);
        push(64'h0000_0000_FFFF_FFFF, 8'h0F, 1'b1);
        drain(20000, 1'b0);

        // reset while a partial frame is stalled on the bus
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) push({$urandom, $urandom}, 8'hFF, 1'b0);
        tick(5);
        chk("pre_rst_tvalid", 128'(m_axis_tvalid), 1);
        #2;
        rx_reset = 1'b1;
        #1;
        chk("mid_rst_tvalid", 128'(m_axis_tvalid), 0);
        chk("mid_rst_tdata", 128'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 0);
        chk("mid_rst_sts_tvalid", 128'(sts_axis_tvalid), 0);
        chk("mid_rst_rden", 128'(good_fifo_rden), 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        exp_q.delete();
        sts_q.delete();
        mcnt = 0;
        mseq = 0;
        tick(2);
        rx_reset = 1'b0;
        m_axis_tready = 1'b1;
        tick(1);
        push(64'hFACE_FACE_FACE_FACE, 8'h03, 1'b1);
        drain(50, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifm_s2mm_axis.md
Name: ifm_s2mm_axis

Overview:
- Drains the good-frame FIFO, the 73-bit FIFO holding only frames that passed RX filtering, in the s2mm_clk domain.
- Presents each frame on an AXI4-Stream master (64-bit data, keep, last) toward the S2MM DMA engine.
- Emits one status word per frame on a separate AXI4-Stream status master: byte length and frame sequence number.
- Acts as the reader of good_fifo; the RX output FSM is its writer.

Parameters:
- C_LEN_W, 16, width of the byte-length counter; saturates at 2^C_LEN_W-1.
- C_SEQ_W, 16, width of the frame sequence counter; wraps.

Ports:
- s2mm_clk  in  1  clock
- rx_reset  in  1  asynchronous active-high reset
- good_fifo_rdata  in  73  first-word-fall-through head word: [72]=last, [71:64]=byte keep, [63:0]=data
- good_fifo_empty  in  1  FIFO empty; rdata is valid when 0
- good_fifo_rden  out  1  pop head word (combinational)
- m_axis_tdata  out  64  frame data
- m_axis_tkeep  out  8  byte enables
- m_axis_tlast  out  1  last beat of frame
- m_axis_tvalid  out  1  data valid
- m_axis_tready  in  1  DMA accepts data
- sts_axis_tdata  out  32  [C_LEN_W-1:0]=frame byte count; [31:16]=sequence number (C_SEQ_W=16)
- sts_axis_tvalid  out  1  status valid
- sts_axis_tready  in  1  DMA accepts status

Behaviour:
- Reset and clocking:
  - Reset is asynchronous, active-high, rx_reset; clock is s2mm_clk.
  - On reset: all m_axis_*, sts_axis_* outputs = 0; output buffer empty; byte count = 0; sequence = 0; pending-last flag = 0.
  - good_fifo_rden is combinational and therefore 0 while in reset.
- Output buffer:
  - 2-entry skid buffer (entries A = head, B); m_axis_* are driven from entry A registers.
  - A popped FIFO word is written to the first free entry on the next clock edge.
  - m_axis_tvalid rises 1 cycle after good_fifo_rden.
- Pop rule:
  - good_fifo_rden = !good_fifo_empty && (buffer occupancy < 2, counting a same-cycle AXIS transfer as freeing one slot) && !last_block.
  - last_block = good_fifo_rdata[72] && (pending_last || sts_axis_tvalid).
  - pending_last is set when a last word is popped; it clears on the m_axis transfer of that word.
  - Result: at most one tlast word is ever in the buffer, and the status register is always free when a tlast transfers.
- AXIS protocol:
  - Once m_axis_tvalid is asserted, tvalid and tdata/tkeep/tlast stay stable until tready.
  - A transfer occurs on tvalid && tready.
  - On the same cycle as a transfer, entry B shifts to A; a simultaneous pop writes into the freed slot.
  - Sustained throughput is 1 word/clock while tready=1 and the FIFO is non-empty, except for the last_block stalls.
- Byte counting:
  - On each m_axis transfer, count += popcount(tkeep).
  - Count is held at all-ones once it would overflow (saturating).
  - On a transfer with tlast: next cycle sts_axis_tdata = {seq, count including this beat}, sts_axis_tvalid = 1; count resets to 0; seq increments (wraps).
  - A tlast beat with tkeep=0 contributes 0 bytes and still produces status.
- Status channel:
  - sts_axis_tvalid holds until sts_axis_tready; it clears on the handshake cycle.
  - The next frame's data beats continue to flow while status is pending; only that frame's last word is held in the FIFO.
- Single-beat frames (one word with last=1) are legal and yield a status count of popcount(keep).
- No frame boundary is inferred from FIFO empty; a partial frame simply stalls tvalid low.

Test Plan:
- Single frame of 3 words, keep FF,FF,0F, tready=1, sts_tready=1 → 3 beats on m_axis, tlast on beat 3; status 0x0000_0014 (seq 0, 20 bytes) one cycle after beat 3.
- Back-to-back two 1-word frames (keep 01, FF), sts_tready=0 → first frame transfers, status 0x0000_0001 held; second word not popped (rden=0) until sts_tready=1; then status 0x0001_0008.
- Random tready backpressure over a 64-word frame with full keep → no data loss or duplication, tdata stable while stalled; status length 512.
- FIFO empties mid-frame for 5 cycles → tvalid=0 during the gap, no tlast emitted; frame resumes; final count correct.
- 70,000-byte frame (8750 full words) with C_LEN_W=16 → status length saturates at 0xFFFF; the next frame's count starts at 0.
- Assert rx_reset mid-frame with tvalid=1 → all outputs 0 immediately; after release, seq=0 and next status carries seq 0.
